tb_timer: RTL and testbench

//  8-bit APB-programmable timer/counter with a selectable internal clock prescaler.
//  The prescaler divides pclk by 2/4/8/16 to form clk_cnt. The counter steps once per rising edge of clk_cnt.

---
 rtl/tb_timer_pkg.sv | 37 +++
 rtl/tb_timer_clkdiv.sv | 44 ++++
 rtl/tb_timer.sv | 151 +++++++++++++++
 tb/tb_tb_timer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_timer_pkg.sv
// Shared constants for the tb_timer APB timer: register map, prescaler
// select encodings, TCR bit positions and the reference pclk period.
`timescale 1ns/1ps
package tb_timer_pkg;

    // Register addresses
    localparam logic [7:0] ADDR_TDR  = 8'h00;
    localparam logic [7:0] ADDR_TCR  = 8'h01;
    localparam logic [7:0] ADDR_TSR  = 8'h02;
    localparam logic [7:0] ADDR_TCNT = 8'h03;
    localparam logic [7:0] ADDR_TIER = 8'h04;

    // Prescaler select: clk_cnt = pclk / 2^(cks+1)
    typedef enum logic [1:0] {
        CLK_2  = 2'b00,
        CLK_4  = 2'b01,
        CLK_8  = 2'b10,
        CLK_16 = 2'b11
    } cks_e;

    // TCR bit positions
    localparam int unsigned TCR_CKS_LSB  = 0;
    localparam int unsigned TCR_EN_BIT   = 4;
    localparam int unsigned TCR_DOWN_BIT = 5;
    localparam int unsigned TCR_LOAD_BIT = 7;

    // Writable TCR bits; reserved bits 2, 3 and 6 always read 0
    localparam logic [7:0] TCR_MASK = 8'hB3;

    // TSR status bit positions
    localparam int unsigned TSR_OVF_BIT = 0;
    localparam int unsigned TSR_UDF_BIT = 1;

    // Reference pclk period in ns for benches
    localparam int unsigned PCLK_PERIOD = 10;

endpackage

// File: rtl/tb_timer_clkdiv.sv
// Prescaler for tb_timer: 4-bit free-running counter, cks tap select,
// restart on cks change and a registered rising-edge detect of clk_cnt.
`timescale 1ns/1ps
module tb_timer_clkdiv
    import tb_timer_pkg::*;
(
    input  logic pclk,
    input  logic preset,
    input  cks_e cks,
    input  logic cks_wr,
    output logic clk_cnt,
    output logic pos_clk_int
);

    logic [3:0] presc_q, presc_d;
    logic       clk_prev_q, clk_prev_d;
    logic       pos_q, pos_d;
    logic [1:0] sel;

    // Next-state: count, or restart from 0 when the tap changes so the new clock starts clean
    always_comb begin
        sel        = cks;
        presc_d    = cks_wr ? '0 : presc_q + 4'd1;
        clk_cnt    = presc_q[sel];
        clk_prev_d = clk_cnt;
        pos_d      = clk_cnt & ~clk_prev_q;
    end

    // Prescaler and edge-detect registers
    always_ff @(posedge pclk) begin
        if (preset) begin
            presc_q    <= '0;
            clk_prev_q <= 1'b0;
            pos_q      <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            clk_prev_q <= clk_prev_d;
            pos_q      <= pos_d;
        end
    end

    assign pos_clk_int = pos_q;

endmodule

// File: rtl/tb_timer.sv
// tb_timer: 8-bit APB timer/counter with selectable prescaler.
// Registers: TDR 0x00, TCR 0x01, TSR 0x02, TCNT 0x03 (read-only).
// Optional feature macro TIMER_IRQ_EN adds TIER 0x04 and the irq output.
`timescale 1ns/1ps
module tb_timer
    import tb_timer_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          pclk,
    input  logic          preset,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-1:0] paddr,
    input  logic [DW-1:0] pwdata,
    output logic [DW-1:0] prdata,
    output logic          pready,
    output logic          pslverr,
    output logic          clk_cnt
`ifdef TIMER_IRQ_EN
    ,
    output logic          irq
`endif
);

    logic [DW-1:0] tdr_q, tdr_d;
    logic [DW-1:0] tcr_q, tcr_d;
    logic [1:0]    tsr_q, tsr_d;
    logic [DW-1:0] tcnt_q, tcnt_d;
`ifdef TIMER_IRQ_EN
    logic [1:0]    tier_q, tier_d;
    logic          irq_q, irq_d;
`endif

    logic access, wr;
    logic sel_tdr, sel_tcr, sel_tsr, sel_tcnt, sel_tier, mapped;
    logic cks_wr, pos_clk_int, ovf_set, udf_set;

    assign pready = 1'b1;

    // Address decode, error response and read mux
    always_comb begin
        access   = psel & penable;
        wr       = access & pwrite;
        sel_tdr  = (paddr == AW'(ADDR_TDR));
        sel_tcr  = (paddr == AW'(ADDR_TCR));
        sel_tsr  = (paddr == AW'(ADDR_TSR));
        sel_tcnt = (paddr == AW'(ADDR_TCNT));
`ifdef TIMER_IRQ_EN
        sel_tier = (paddr == AW'(ADDR_TIER));
`else
        sel_tier = 1'b0;
`endif
        mapped   = sel_tdr | sel_tcr | sel_tsr | sel_tcnt | sel_tier;
        pslverr  = access & ~mapped;
        prdata   = '0;
        if (sel_tdr)  prdata = tdr_q;
        if (sel_tcr)  prdata = tcr_q;
        if (sel_tsr)  prdata = {{(DW-2){1'b0}}, tsr_q};
        if (sel_tcnt) prdata = tcnt_q;
`ifdef TIMER_IRQ_EN
        if (sel_tier) prdata = {{(DW-2){1'b0}}, tier_q};
`endif
    end

    // Register writes; a changed cks restarts the prescaler
    always_comb begin
        tdr_d  = tdr_q;
        tcr_d  = tcr_q;
        cks_wr = 1'b0;
`ifdef TIMER_IRQ_EN
        tier_d = tier_q;
`endif
        if (wr && sel_tdr) tdr_d = pwdata;
        if (wr && sel_tcr) begin
            tcr_d  = pwdata & DW'(TCR_MASK);
            cks_wr = (pwdata[1:0] != tcr_q[1:0]);
        end
`ifdef TIMER_IRQ_EN
        if (wr && sel_tier) tier_d = pwdata[1:0];
`endif
    end

    // Counter load/step and wrap detection
    always_comb begin
        tcnt_d  = tcnt_q;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (tcr_q[TCR_LOAD_BIT]) begin
            tcnt_d = tdr_q;
        end else if (tcr_q[TCR_EN_BIT] && pos_clk_int) begin
            if (tcr_q[TCR_DOWN_BIT]) begin
                tcnt_d  = tcnt_q - 1'b1;
                udf_set = (tcnt_q == '0);
            end else begin
                tcnt_d  = tcnt_q + 1'b1;
                ovf_set = (tcnt_q == '1);
            end
        end
    end

    // Sticky status: write-0-to-clear, with a same-cycle set taking priority
    always_comb begin
        tsr_d = tsr_q;
        if (wr && sel_tsr) tsr_d = tsr_q & pwdata[1:0];
        tsr_d[TSR_OVF_BIT] = tsr_d[TSR_OVF_BIT] | ovf_set;
        tsr_d[TSR_UDF_BIT] = tsr_d[TSR_UDF_BIT] | udf_set;
`ifdef TIMER_IRQ_EN
        irq_d = |(tsr_q & tier_q);
`endif
    end

    // State registers
    always_ff @(posedge pclk) begin
        if (preset) begin
            tdr_q  <= '0;
            tcr_q  <= '0;
            tsr_q  <= '0;
            tcnt_q <= '0;
`ifdef TIMER_IRQ_EN
            tier_q <= '0;
            irq_q  <= 1'b0;
`endif
        end else begin
            tdr_q  <= tdr_d;
            tcr_q  <= tcr_d;
            tsr_q  <= tsr_d;
            tcnt_q <= tcnt_d;
`ifdef TIMER_IRQ_EN
            tier_q <= tier_d;
            irq_q  <= irq_d;
`endif
        end
    end

`ifdef TIMER_IRQ_EN
    assign irq = irq_q;
`endif

    tb_timer_clkdiv u_clkdiv (
        .pclk        (pclk),
        .preset      (preset),
        .cks         (cks_e'(tcr_q[TCR_CKS_LSB +: 2])),
        .cks_wr      (cks_wr),
        .clk_cnt     (clk_cnt),
        .pos_clk_int (pos_clk_int)
    );

endmodule

// File: tb/tb_tb_timer.sv
// Self-checking bench for tb_timer: table of APB vectors checked through an
// expectation queue, plus sequences for divider timing, counting, hold and reset.
`timescale 1ns/1ps
module tb_tb_timer;
    import tb_timer_pkg::*;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0] paddr = '0, pwdata = '0;
    logic [7:0] prdata;
    logic       pready, pslverr, clk_cnt;
`ifdef TIMER_IRQ_EN
    logic       irq;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic       exp_err;
    } vec_t;

    typedef struct {
        int         idx;
        logic       chk_rd;
        logic [7:0] exp_rd;
        logic       exp_err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    tb_timer #(.DW(8), .AW(8)) dut (
        .pclk    (pclk),
        .preset  (preset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .clk_cnt (clk_cnt)
`ifdef TIMER_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    always #(PCLK_PERIOD/2) pclk = ~pclk;

    initial begin
        #(PCLK_PERIOD * 40000);
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic apb(input logic w, input logic [7:0] a, input logic [7:0] d,
                       output logic [7:0] rd, output logic err);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        rd  = prdata;
        err = pslverr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] rd;
        logic       err;
        apb(1'b1, a, d, rd, err);
    endtask

    task automatic rd_check(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] rd;
        logic       err;
        apb(1'b0, a, 8'h00, rd, err);
        check(name, {24'h0, rd}, {24'h0, exp});
    endtask

    task automatic do_reset();
        @(posedge pclk); #1;
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
    endtask

    // Wait (bounded) for prdata to differ from prev while paddr selects TCNT
    task automatic wait_change(input logic [7:0] prev, output logic [7:0] val,
                               output int cyc, output bit ok);
        ok = 1'b0; cyc = 0; val = prev;
        for (int i = 0; i < 200; i++) begin
            @(negedge pclk);
            cyc++;
            if (prdata !== prev) begin
                val = prdata; ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic add(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] er, input logic ee);
        vec_t v;
        v.wr = w; v.addr = a; v.wdata = d; v.exp_rd = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] rd, val, prev;
        logic       err;
        int         cyc;
        bit         ok;
        logic       irq_on;
        exp_t       e;

`ifdef TIMER_IRQ_EN
        irq_on = 1'b1;
`else
        irq_on = 1'b0;
`endif
        // Bus vector table (applied straight after reset)
        add(0, ADDR_TDR,  8'h00, 8'h00, 0);
        add(0, ADDR_TCR,  8'h00, 8'h00, 0);
        add(0, ADDR_TSR,  8'h00, 8'h00, 0);
        add(0, ADDR_TCNT, 8'h00, 8'h00, 0);
        add(1, ADDR_TDR,  8'h5A, 8'h00, 0);
        add(0, ADDR_TDR,  8'h00, 8'h5A, 0);
        add(1, ADDR_TCNT, 8'hAA, 8'h00, 0);
        add(0, ADDR_TCNT, 8'h00, 8'h00, 0);
        add(0, 8'h07,     8'h00, 8'h00, 1);
        add(1, 8'h07,     8'h11, 8'h00, 1);
        add(0, ADDR_TIER, 8'h00, 8'h00, !irq_on);
        add(1, ADDR_TIER, 8'hFF, 8'h00, !irq_on);
        add(0, ADDR_TIER, 8'h00, irq_on ? 8'h03 : 8'h00, !irq_on);
        add(1, ADDR_TIER, 8'h00, 8'h00, !irq_on);
        add(1, ADDR_TSR,  8'hFF, 8'h00, 0);
        add(0, ADDR_TSR,  8'h00, 8'h00, 0);
        add(1, ADDR_TCR,  8'hBF, 8'h00, 0);
        add(0, ADDR_TCR,  8'h00, 8'hB3, 0);
        add(0, ADDR_TCNT, 8'h00, 8'h5A, 0);
        add(1, ADDR_TCR,  8'h00, 8'h00, 0);
        add(0, ADDR_TCR,  8'h00, 8'h00, 0);
        add(0, ADDR_TCNT, 8'h00, 8'h5A, 0);

        // Reset state
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("rst_clk_cnt", {31'h0, clk_cnt}, 32'h0);
        check("pready", {31'h0, pready}, 32'h1);
`ifdef TIMER_IRQ_EN
        check("rst_irq", {31'h0, irq}, 32'h0);
`endif
        @(posedge pclk); #1 preset = 1'b0;

        // Table-driven bus checks through the expectation queue
        foreach (vecs[i]) begin
            e.idx = i; e.chk_rd = !vecs[i].wr;
            e.exp_rd = vecs[i].exp_rd; e.exp_err = vecs[i].exp_err;
            sb.push_back(e);
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err);
            e = sb.pop_front();
            check($sformatf("vec%0d_err", e.idx), {31'h0, err}, {31'h0, e.exp_err});
            if (e.chk_rd)
                check($sformatf("vec%0d_rd", e.idx), {24'h0, rd}, {24'h0, e.exp_rd});
        end

        // Divider periods: 20 clk_cnt periods per cks setting
        for (int k = 0; k < 4; k++) begin
            longint t0, t1;
            int     rises;
            logic   last;
            wr_reg(ADDR_TCR, 8'(k));
            #100;
            rises = 0; t0 = 0; t1 = 0;
            @(negedge pclk); last = clk_cnt;
            for (int c = 0; c < 1000 && rises < 21; c++) begin
                @(negedge pclk);
                if (clk_cnt && !last) begin
                    if (rises == 0) t0 = $time;
                    t1 = $time;
                    rises++;
                end
                last = clk_cnt;
            end
            if (rises < 21)
                check($sformatf("div%0d_rises", k), rises, 21);
            else
                check($sformatf("div%0d_period", k), 32'(t1 - t0),
                      32'(20 * (2 << k) * PCLK_PERIOD));
        end

        // Up-count with overflow
        do_reset();
        wr_reg(ADDR_TDR, 8'hFD);
        wr_reg(ADDR_TCR, 8'h80);
        wr_reg(ADDR_TCR, 8'h10);
        paddr = ADDR_TCNT;
        @(negedge pclk);
        check("up_start", {24'h0, prdata}, 32'hFD);
        prev = 8'hFD;
        for (int n = 0; n < 3; n++) begin
            wait_change(prev, val, cyc, ok);
            check($sformatf("up_tick%0d_seen", n), {31'h0, ok}, 32'h1);
            check($sformatf("up_tick%0d_val", n), {24'h0, val}, {24'h0, 8'(8'hFE + n)});
            if (n > 0) check($sformatf("up_tick%0d_gap", n), cyc, 2);
            prev = val;
        end
        rd_check("up_tsr_ovf", ADDR_TSR, 8'h01);
        wr_reg(ADDR_TSR, 8'h00);
        rd_check("up_tsr_clr", ADDR_TSR, 8'h00);

        // Down-count with underflow at CLK_16
        do_reset();
        wr_reg(ADDR_TDR, 8'h02);
        wr_reg(ADDR_TCR, 8'h80);
        wr_reg(ADDR_TCR, 8'h33);
        paddr = ADDR_TCNT;
        @(negedge pclk);
        check("dn_start", {24'h0, prdata}, 32'h02);
        prev = 8'h02;
        for (int n = 0; n < 3; n++) begin
            wait_change(prev, val, cyc, ok);
            check($sformatf("dn_tick%0d_seen", n), {31'h0, ok}, 32'h1);
            check($sformatf("dn_tick%0d_val", n), {24'h0, val}, {24'h0, 8'(8'h01 - n)});
            if (n > 0) check($sformatf("dn_tick%0d_gap", n), cyc, 16);
            prev = val;
        end
        rd_check("dn_tsr_udf", ADDR_TSR, 8'h02);

        // Enable off holds; load tracks TDR
        do_reset();
        wr_reg(ADDR_TDR, 8'h3C);
        wr_reg(ADDR_TCR, 8'h80);
        wr_reg(ADDR_TCR, 8'h00);
        repeat (50) @(posedge pclk);
        rd_check("hold_en0", ADDR_TCNT, 8'h3C);
        wr_reg(ADDR_TDR, 8'h55);
        wr_reg(ADDR_TCR, 8'h91);
        rd_check("load_55", ADDR_TCNT, 8'h55);
        repeat (40) @(posedge pclk);
        rd_check("load_held", ADDR_TCNT, 8'h55);

        // Reset mid-count with an APB write in flight
        do_reset();
        wr_reg(ADDR_TDR, 8'h40);
        wr_reg(ADDR_TCR, 8'h10);
        repeat (10) @(posedge pclk);
        #1;
        preset = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
        paddr = ADDR_TDR; pwdata = 8'h77;
        @(negedge pclk);
        @(negedge pclk);
        check("midrst_clk_cnt", {31'h0, clk_cnt}, 32'h0);
        @(posedge pclk); #1;
        preset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        rd_check("midrst_tdr",  ADDR_TDR,  8'h00);
        rd_check("midrst_tcr",  ADDR_TCR,  8'h00);
        rd_check("midrst_tsr",  ADDR_TSR,  8'h00);
        rd_check("midrst_tcnt", ADDR_TCNT, 8'h00);

`ifdef TIMER_IRQ_EN
        // irq follows TSR[0] by one cycle when ovf_ie is set
        do_reset();
        wr_reg(ADDR_TIER, 8'h01);
        wr_reg(ADDR_TDR, 8'hFE);
        wr_reg(ADDR_TCR, 8'h80);
        wr_reg(ADDR_TCR, 8'h10);
        paddr = ADDR_TSR;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge pclk);
            if (prdata[0] === 1'b1) ok = 1'b1;
        end
        check("irq_ovf_seen", {31'h0, ok}, 32'h1);
        check("irq_same_cycle", {31'h0, irq}, 32'h0);
        @(negedge pclk);
        check("irq_next_cycle", {31'h0, irq}, 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
